vend_txn_ctrl: RTL

Transaction controller for the vending machine. It sits between the button conditioner, the item dispenser and the display driver. It consumes single-cycle coin/buy/cancel events and a switch-based item selection, tracks credit in cents, and sequences the dispense handshake. It then pays out change one quarter at a time, and auto-refunds an abandoned transaction after an inactivity timeout.

---
 rtl/vend_txn_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/vend_txn_ctrl.sv
// vend_txn_ctrl: vending transaction controller that tracks credit, runs the dispense handshake,
// pays out change one quarter at a time and refunds an abandoned transaction after a timeout.
module vend_txn_ctrl #(
  parameter int CW         = 11,
  parameter int PRICE_A    = 100,
  parameter int PRICE_B    = 150,
  parameter int PRICE_C    = 200,
  parameter int MAX_CREDIT = 500,
  parameter int TIMEOUT    = 1000,
  parameter int CHANGE_GAP = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          coin_q,
  input  logic          coin_d,
  input  logic          btn_buy,
  input  logic          btn_cancel,
  input  logic [2:0]    sel,
  input  logic          disp_ack,
  output logic [CW-1:0] credit,
  output logic          disp_req,
  output logic [1:0]    disp_item,
  output logic          change_pulse,
  output logic          coin_reject,
  output logic          short_flag
);
  localparam int TW = $clog2(TIMEOUT);
  localparam int GW = $clog2(CHANGE_GAP);
  typedef enum logic [1:0] {IDLE, CREDIT, DISPENSE, CHANGE} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic          req_q, req_d;
  logic [1:0]    item_q, item_d;
  logic          chg_q, chg_d;
  logic          rej_q, rej_d;
  logic          short_q, short_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          coin_any, coin_ok, sel_ok;
  logic [CW:0]   coin_val, sum;
  logic [CW-1:0] price;
  logic [1:0]    item;
  always_comb begin
    coin_any = coin_q | coin_d;
    coin_val = coin_d ? (CW+1)'(100) : (CW+1)'(25);
    sum      = {1'b0, credit_q} + coin_val;
    // a cancel in CREDIT takes precedence, so any coin alongside it is bounced
    coin_ok  = coin_any && (state_q == IDLE || (state_q == CREDIT && !btn_cancel)) &&
               sum <= (CW+1)'(MAX_CREDIT);
    sel_ok   = sel == 3'b001 || sel == 3'b010 || sel == 3'b100;
    price    = sel[0] ? CW'(PRICE_A) : sel[1] ? CW'(PRICE_B) : CW'(PRICE_C);
    item     = sel[0] ? 2'd0 : sel[1] ? 2'd1 : 2'd2;
    state_d  = state_q;
    credit_d = credit_q;
    req_d    = req_q;
    item_d   = item_q;
    chg_d    = 1'b0;
    rej_d    = coin_any && (!coin_ok || (coin_q && coin_d));
    short_d  = 1'b0;
    tmr_d    = '0;
    gap_d    = '0;
    case (state_q)
      IDLE: begin
        if (coin_any) begin
          if (coin_ok) begin
            credit_d = sum[CW-1:0];
            state_d  = CREDIT;
          end
        end else if (btn_buy) short_d = 1'b1;
      end
      CREDIT: begin
        if (btn_cancel) state_d = CHANGE;
        else if (coin_any) begin
          if (coin_ok) credit_d = sum[CW-1:0];
        end else if (btn_buy) begin
          if (sel_ok && credit_q >= price) begin
            credit_d = credit_q - price;
            item_d   = item;
            req_d    = 1'b1;
            state_d  = DISPENSE;
          end else short_d = 1'b1;
        end else if (tmr_q == TW'(TIMEOUT - 1)) state_d = CHANGE;
        else tmr_d = tmr_q + TW'(1);
      end
      DISPENSE: begin
        if (disp_ack) begin
          req_d   = 1'b0;
          state_d = credit_q != '0 ? CHANGE : IDLE;
        end
      end
      CHANGE: begin
        if (gap_q == '0) begin
          chg_d    = 1'b1;
          credit_d = credit_q - CW'(25);
          gap_d    = GW'(CHANGE_GAP - 1);
          state_d  = credit_q == CW'(25) ? IDLE : CHANGE;
        end else gap_d = gap_q - GW'(1);
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      credit_q <= '0;
      req_q    <= 1'b0;
      item_q   <= 2'd0;
      chg_q    <= 1'b0;
      rej_q    <= 1'b0;
      short_q  <= 1'b0;
      tmr_q    <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      req_q    <= req_d;
      item_q   <= item_d;
      chg_q    <= chg_d;
      rej_q    <= rej_d;
      short_q  <= short_d;
      tmr_q    <= tmr_d;
      gap_q    <= gap_d;
    end
  end
  assign credit       = credit_q;
  assign disp_req     = req_q;
  assign disp_item    = item_q;
  assign change_pulse = chg_q;
  assign coin_reject  = rej_q;
  assign short_flag   = short_q;
endmodule
